// File: rtl/usr_pkg.sv
// Shared constants for the universal shift register: mode select encodings
// and the default register width.
package usr_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Mode select encodings; each value is also the mux data index for that mode.
  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

endpackage : usr_pkg

// File: rtl/D_FF_asynRst.sv
// Rising-edge D flip-flop with asynchronous active-low clear.
// Optional macro USR_QBAR_EN adds the complementary output Qbar (resets to 1).
module D_FF_asynRst (
  output logic Q,
`ifdef USR_QBAR_EN
  output logic Qbar,
`endif
  input  logic D,
  input  logic Clk,
  input  logic Rst
);

  // State flop: cleared immediately while Rst is low, otherwise captures D.
  // NOTE: non-blocking assignment so every flop in the bank samples its mux
  // output from before the edge; blocking here would ripple a shift through
  // several bits in one cycle depending on evaluation order.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) Q <= 1'b0;
    else      Q <= D;
  end

`ifdef USR_QBAR_EN
  // Complement derived from the stored bit, so it can never disagree with Q.
  assign Qbar = ~Q;
`endif

endmodule : D_FF_asynRst

// File: rtl/Mux_4.sv
// 4:1 single-bit mux: Y = data[sel].
// An X/Z select is deliberately not masked, so it propagates X to Y.
module Mux_4 (
  output logic       Y,
  input  logic [3:0] data,
  input  logic [1:0] sel
);

  // Plain indexed select keeps X on sel visible instead of defaulting it away.
  assign Y = data[sel];

endmodule : Mux_4

// File: rtl/mux4_d_ff_asyn_rst.sv
// Universal shift register: WIDTH flops, each fed by a 4:1 mux selecting
// hold / shift toward bit 0 / shift toward MSB / parallel load.
// Optional macro USR_QBAR_EN exports Qn = ~Q (all ones in reset).
module mux4_d_ff_asyn_rst
  import usr_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [1:0]       SelectLines,
  input  logic [WIDTH-1:0] In,
  input  logic             ShiftRight,
  input  logic             ShiftLeft,
  output logic [WIDTH-1:0] Q
`ifdef USR_QBAR_EN
  ,
  output logic [WIDTH-1:0] Qn
`endif
);

  wire  [WIDTH-1:0] qReg;
  wire  [WIDTH-1:0] nextBit;
  logic [WIDTH-1:0] shrSrc;
  logic [WIDTH-1:0] shlSrc;
  logic [3:0]       muxData [WIDTH];

  // Neighbour sources: serial inputs enter at the end bits; the bit shifted
  // out at the opposite end simply has no consumer (no wrap-around).
  assign shrSrc = {ShiftRight, qReg[WIDTH-1:1]};
  assign shlSrc = {qReg[WIDTH-2:0], ShiftLeft};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    // Mux inputs ordered by mode code so SelectLines indexes them directly.
    always_comb begin
      muxData[i]           = '0;
      muxData[i][SEL_HOLD] = qReg[i];
      muxData[i][SEL_SHR]  = shrSrc[i];
      muxData[i][SEL_SHL]  = shlSrc[i];
      muxData[i][SEL_LOAD] = In[i];
    end

    Mux_4 u_mux (
      .Y    (nextBit[i]),
      .data (muxData[i]),
      .sel  (SelectLines)
    );

`ifdef USR_QBAR_EN
    D_FF_asynRst u_ff (
      .Q    (qReg[i]),
      .Qbar (Qn[i]),
      .D    (nextBit[i]),
      .Clk  (Clk),
      .Rst  (Rst)
    );
`else
    D_FF_asynRst u_ff (
      .Q    (qReg[i]),
      .D    (nextBit[i]),
      .Clk  (Clk),
      .Rst  (Rst)
    );
`endif
  end : g_bit

  assign Q = qReg;

endmodule : mux4_d_ff_asyn_rst

// File: tb/tb_mux4_d_ff_asyn_rst.sv
// Scoreboard bench for mux4_d_ff_asyn_rst (WIDTH=4). Stimulus pushes the
// expected register value into a queue; a monitor pops and compares either at
// the falling edge after a capture, or immediately on an asynchronous event.
module tb_mux4_d_ff_asyn_rst;

  localparam int W = 4;

  typedef struct {
    string        name;
    logic [W-1:0] q;
  } exp_t;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [1:0]   SelectLines;
  logic [W-1:0] In;
  logic         ShiftRight;
  logic         ShiftLeft;
  logic [W-1:0] Q;
`ifdef USR_QBAR_EN
  logic [W-1:0] Qn;
`endif

  exp_t expQ[$];
  event checkNow;
  int   nCompared   = 0;
  int   nMismatched = 0;

  mux4_d_ff_asyn_rst #(.WIDTH(W)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .SelectLines (SelectLines),
    .In          (In),
    .ShiftRight  (ShiftRight),
    .ShiftLeft   (ShiftLeft),
    .Q           (Q)
`ifdef USR_QBAR_EN
    ,
    .Qn          (Qn)
`endif
  );

  always #5 Clk = ~Clk;

  // Monitor: falling edge for clocked results, checkNow for asynchronous ones.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk or checkNow);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        nCompared++;
        if (Q !== e.q) begin
          nMismatched++;
          $display("FAIL %s: Q=%b expected %b", e.name, Q, e.q);
        end
`ifdef USR_QBAR_EN
        nCompared++;
        if (Qn !== ~e.q) begin
          nMismatched++;
          $display("FAIL %s_qn: Qn=%b expected %b", e.name, Qn, ~e.q);
        end
`endif
      end
    end
  end

  // Drive one cycle of inputs just after a falling edge; the result is
  // checked at the next falling edge, after the intervening rising edge.
  task automatic step(input logic rst, input logic [1:0] sel,
                      input logic [W-1:0] din, input logic sr, input logic sl,
                      input logic [W-1:0] exp, input string name);
    @(negedge Clk);
    #1;
    Rst = rst; SelectLines = sel; In = din; ShiftRight = sr; ShiftLeft = sl;
    expQ.push_back('{name, exp});
  endtask

  // Immediate (clock-independent) check of the current register value.
  task automatic checkAsync(input logic [W-1:0] exp, input string name);
    expQ.push_back('{name, exp});
    ->checkNow;
    #0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time=%0t expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rst = 1'b1; SelectLines = 2'b11; In = 4'b1010; ShiftRight = 1'b0; ShiftLeft = 1'b0;
    // Asynchronous reset before any clock edge.
    #2 Rst = 1'b0;
    #1 checkAsync(4'b0000, "rst_async");
    // Held in reset across edges even with load requested.
    step(1'b0, 2'b11, 4'b1111, 1'b1, 1'b1, 4'b0000, "rst_hold1");
    step(1'b0, 2'b11, 4'b1111, 1'b1, 1'b1, 4'b0000, "rst_hold2");
    // Hold mode for three edges.
    step(1'b1, 2'b00, 4'b1111, 1'b1, 1'b1, 4'b0000, "hold1");
    step(1'b1, 2'b00, 4'b1111, 1'b1, 1'b1, 4'b0000, "hold2");
    step(1'b1, 2'b00, 4'b1111, 1'b1, 1'b1, 4'b0000, "hold3");
    // Parallel load.
    step(1'b1, 2'b11, 4'b1011, 1'b0, 1'b0, 4'b1011, "load");
    // Shift right, serial one entering at the MSB.
    step(1'b1, 2'b01, 4'b0000, 1'b1, 1'b0, 4'b1101, "shr1");
    step(1'b1, 2'b01, 4'b0000, 1'b1, 1'b0, 4'b1110, "shr2");
    step(1'b1, 2'b01, 4'b0000, 1'b1, 1'b0, 4'b1111, "shr3");
    // Reload, then shift left with zero entering at bit 0.
    step(1'b1, 2'b11, 4'b1011, 1'b1, 1'b1, 4'b1011, "reload");
    step(1'b1, 2'b10, 4'b0000, 1'b1, 1'b0, 4'b0110, "shl1");
    step(1'b1, 2'b10, 4'b0000, 1'b1, 1'b0, 4'b1100, "shl2");
    // End-bit behaviour: MSB discarded on left shift, LSB on right shift.
    step(1'b1, 2'b10, 4'b0000, 1'b0, 1'b1, 4'b1001, "shl_one_in");
    step(1'b1, 2'b01, 4'b0000, 1'b0, 1'b1, 4'b0100, "shr_zero_in");
    step(1'b1, 2'b11, 4'b1011, 1'b0, 1'b0, 4'b1011, "load2");
    step(1'b1, 2'b01, 4'b0000, 1'b1, 1'b0, 4'b1101, "shr_pre_rst");
    // Reset pulse mid-shift, between clock edges.
    @(negedge Clk);
    #1 Rst = 1'b0;
    #1 checkAsync(4'b0000, "rst_mid");
    #1 Rst = 1'b1; SelectLines = 2'b11; In = 4'b1011;
    expQ.push_back('{"load_after_rst", 4'b1011});
    // Let the scoreboard drain, bounded.
    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge Clk);
    #1;
    if (expQ.size() > 0) begin
      nMismatched++;
      $display("FAIL drain: pending=%0d expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule : tb_mux4_d_ff_asyn_rst
